// File: rtl/policy_controller.sv
// -----------------------------------------------------------------------------
// policy_controller
//
// Purpose:
//   Sequences one epsilon-greedy action decision per start request. A decision
//   reads the four Q-values for the current environment state from an external
//   Q-table, presents them (with a frozen copy of epsilon) to a combinational
//   policy generator, and registers the action that comes back. Epsilon decays
//   linearly toward a floor on every episode_end pulse. step_count counts the
//   actions issued in the current episode.
//
// Handshake semantics (single comment, applies to every strobe here):
//   start        - one-cycle request, accepted only when the FSM is IDLE
//                  (busy=0). A start seen while busy is dropped, never queued.
//   qt_rd_en     - one-cycle read strobe; qt_rd_data must be valid on the
//                  cycle after the strobe (fixed one-cycle read latency).
//   action_valid - one-cycle pulse; action is stable from this pulse until
//                  the next decision's EVAL cycle.
//   episode_end  - one-cycle pulse, honoured in any FSM state.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous active-high reset
//   start        in   1   request one action decision
//   state_in     in   4   environment state, sampled with start
//   episode_end  in   1   end-of-episode pulse
//   qt_rd_en     out  1   Q-table read strobe
//   qt_rd_addr   out  4   Q-table read address
//   qt_rd_data   in   64  four Q8.8 Q-values
//   pg_q_values  out  64  Q-values to the policy generator
//   pg_epsilon   out  16  epsilon snapshot to the policy generator
//   pg_action    in   4   combinational action from the policy generator
//   action       out  4   registered chosen action
//   action_valid out  1   action valid pulse
//   busy         out  1   decision in progress
//   epsilon      out  16  live epsilon register
//   step_count   out  16  actions issued this episode (saturating)
// -----------------------------------------------------------------------------
module policy_controller #(
   parameter logic [15:0] EPS_INIT  = 16'h00E0,
   parameter logic [15:0] EPS_MIN   = 16'h0010,
   parameter logic [15:0] EPS_DECAY = 16'h0008
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  state_in,
   input  logic        episode_end,
   output logic        qt_rd_en,
   output logic [3:0]  qt_rd_addr,
   input  logic [63:0] qt_rd_data,
   output logic [63:0] pg_q_values,
   output logic [15:0] pg_epsilon,
   input  logic [3:0]  pg_action,
   output logic [3:0]  action,
   output logic        action_valid,
   output logic        busy,
   output logic [15:0] epsilon,
   output logic [15:0] step_count
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      WAIT = 3'd2,
      EVAL = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [3:0]  addr;
   logic [15:0] eps_snap;
   logic [63:0] q_reg;
   logic [15:0] eps_decayed;

   // Threshold computed one bit wider so EPS_MIN + EPS_DECAY cannot wrap.
   localparam logic [16:0] EPS_FLOOR_SUM = {1'b0, EPS_MIN} + {1'b0, EPS_DECAY};

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next-state and state-decoded outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next   = state;
      qt_rd_en     = 1'b0;
      action_valid = 1'b0;
      busy         = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = READ;
            end
         end
         READ: begin
            qt_rd_en   = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            state_next = EVAL;
         end
         EVAL: begin
            state_next = DONE;
         end
         DONE: begin
            action_valid = 1'b1;
            state_next   = IDLE;
         end
         default: begin
            busy       = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Epsilon decay: anything at or below floor+decay lands exactly on the
   // floor, so the subtraction below never underflows.
   // ---------------------------------------------------------------------------
   always_comb begin
      eps_decayed = epsilon - EPS_DECAY;
      if ({1'b0, epsilon} <= EPS_FLOOR_SUM) begin
         eps_decayed = EPS_MIN;
      end
   end

   // ---------------------------------------------------------------------------
   // Decision datapath
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr     <= 4'h0;
         eps_snap <= EPS_INIT;
         q_reg    <= 64'h0;
         action   <= 4'h0;
      end else begin
         // Snapshot takes the pre-decay epsilon even if episode_end coincides.
         if (state == IDLE && start) begin
            addr     <= state_in;
            eps_snap <= epsilon;
         end
         if (state == WAIT) begin
            q_reg <= qt_rd_data;
         end
         if (state == EVAL) begin
            action <= pg_action;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Episode bookkeeping: epsilon and per-episode step counter
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         epsilon    <= EPS_INIT;
         step_count <= 16'h0;
      end else begin
         if (episode_end) begin
            epsilon <= eps_decayed;
         end
         // Clearing on episode_end has priority over counting the action.
         if (episode_end) begin
            step_count <= 16'h0;
         end else if (action_valid && step_count != 16'hFFFF) begin
            step_count <= step_count + 16'h1;
         end
      end
   end

   assign qt_rd_addr  = addr;
   assign pg_q_values = q_reg;
   assign pg_epsilon  = eps_snap;

endmodule

// File: tb/tb_policy_controller.sv
// -----------------------------------------------------------------------------
// tb_policy_controller
//
// Purpose:
//   Self-checking bench for policy_controller. Provides a one-cycle-latency
//   Q-table model and a combinational policy-generator stub, drives decisions
//   and episode pulses, and keeps an expected-action queue that is drained
//   whenever the controller pulses action_valid.
// -----------------------------------------------------------------------------
module tb_policy_controller;

   localparam logic [15:0] EPS_INIT  = 16'h00E0;
   localparam logic [15:0] EPS_MIN   = 16'h0010;
   localparam logic [15:0] EPS_DECAY = 16'h0008;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic        clk;
   logic        rst;
   logic        start;
   logic [3:0]  state_in;
   logic        episode_end;
   logic        qt_rd_en;
   logic [3:0]  qt_rd_addr;
   logic [63:0] qt_rd_data;
   logic [63:0] pg_q_values;
   logic [15:0] pg_epsilon;
   logic [3:0]  pg_action;
   logic [3:0]  action;
   logic        action_valid;
   logic        busy;
   logic [15:0] epsilon;
   logic [15:0] step_count;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   policy_controller #(
      .EPS_INIT  (EPS_INIT),
      .EPS_MIN   (EPS_MIN),
      .EPS_DECAY (EPS_DECAY)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .state_in     (state_in),
      .episode_end  (episode_end),
      .qt_rd_en     (qt_rd_en),
      .qt_rd_addr   (qt_rd_addr),
      .qt_rd_data   (qt_rd_data),
      .pg_q_values  (pg_q_values),
      .pg_epsilon   (pg_epsilon),
      .pg_action    (pg_action),
      .action       (action),
      .action_valid (action_valid),
      .busy         (busy),
      .epsilon      (epsilon),
      .step_count   (step_count)
   );

   // ---------------------------------------------------------------------------
   // Environment models: Q-table (one-cycle read latency) and policy stub
   // ---------------------------------------------------------------------------
   logic [63:0] q_table [16];

   function automatic logic [3:0] pg_model(input logic [63:0] q, input logic [15:0] e);
      return q[3:0] ^ q[51:48] ^ e[7:4];
   endfunction

   initial qt_rd_data = 64'h0;
   always @(posedge clk) begin
      if (qt_rd_en) qt_rd_data <= q_table[qt_rd_addr];
   end

   assign pg_action = pg_model(pg_q_values, pg_epsilon);

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   int          n_cmp = 0;
   int          n_err = 0;
   int          av_count = 0;
   logic [3:0]  exp_q[$];
   logic [15:0] eps_model;
   logic [15:0] step_model;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] decay(input logic [15:0] e);
      int t;
      t = int'(e) - int'(EPS_DECAY);
      if (t < int'(EPS_MIN)) t = int'(EPS_MIN);
      return t[15:0];
   endfunction

   always @(negedge clk) begin
      if (!rst && action_valid) begin
         av_count++;
         if (exp_q.size() == 0) check("unexpected_action_valid", 1, 0);
         else check("action", action, exp_q.pop_front());
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks (called at a falling edge; inputs change only there)
   // ---------------------------------------------------------------------------
   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      episode_end = 1'b0;
      @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_rd_en", qt_rd_en, 0);
      check("rst_av", action_valid, 0);
      check("rst_action", action, 0);
      check("rst_addr", qt_rd_addr, 0);
      check("rst_epsilon", epsilon, EPS_INIT);
      check("rst_pg_eps", pg_epsilon, EPS_INIT);
      check("rst_pg_q", pg_q_values, 0);
      check("rst_steps", step_count, 0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      eps_model = EPS_INIT;
      step_model = 16'h0;
   endtask

   task automatic pulse_ee();
      episode_end = 1'b1;
      @(negedge clk);
      episode_end = 1'b0;
      eps_model = decay(eps_model);
      step_model = 16'h0;
   endtask

   // One full decision; optional episode_end at start, in READ, or in DONE.
   task automatic decide(input logic [3:0] s, input bit ee_start, input bit ee_mid,
                         input bit ee_done);
      logic [15:0] snap;
      logic [63:0] q;
      snap = eps_model;
      q = q_table[s];
      start = 1'b1;
      state_in = s;
      episode_end = ee_start;
      exp_q.push_back(pg_model(q, snap));
      @(negedge clk);
      start = 1'b0;
      state_in = 4'($urandom_range(0, 15));
      if (ee_start) begin
         episode_end = 1'b0;
         eps_model = decay(eps_model);
         step_model = 16'h0;
      end
      check("read_busy", busy, 1);
      check("read_en", qt_rd_en, 1);
      check("read_addr", qt_rd_addr, s);
      check("read_epsilon", epsilon, eps_model);
      episode_end = ee_mid;
      @(negedge clk);
      if (ee_mid) begin
         episode_end = 1'b0;
         eps_model = decay(eps_model);
         step_model = 16'h0;
      end
      check("wait_en", qt_rd_en, 0);
      check("wait_av", action_valid, 0);
      @(negedge clk);
      check("eval_q", pg_q_values, q);
      check("eval_pg_eps", pg_epsilon, snap);
      check("eval_epsilon", epsilon, eps_model);
      check("eval_av", action_valid, 0);
      @(negedge clk);
      check("done_av", action_valid, 1);
      check("done_busy", busy, 1);
      check("done_steps", step_count, step_model);
      episode_end = ee_done;
      @(negedge clk);
      if (ee_done) begin
         episode_end = 1'b0;
         eps_model = decay(eps_model);
         step_model = 16'h0;
      end else if (step_model != 16'hFFFF) begin
         step_model = step_model + 16'h1;
      end
      check("idle_busy", busy, 0);
      check("idle_av", action_valid, 0);
      check("idle_steps", step_count, step_model);
   endtask

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   initial begin
      logic [15:0] tail [5];
      int base;
      tail = '{16'h0028, 16'h0020, 16'h0018, 16'h0010, 16'h0010};
      start = 1'b0;
      episode_end = 1'b0;
      state_in = 4'h0;
      for (int i = 0; i < 16; i++) q_table[i] = {$urandom, $urandom};
      q_table[5] = 64'h000C_0001_0002_0003;

      // Reset state, then a first decision on the first edge after release.
      do_reset();
      decide(4'h5, 0, 0, 0);
      check("known_action", action, 4'h1);
      check("known_steps", step_count, 1);

      // Assorted decisions, then episode_end during a decision.
      for (int i = 0; i < 4; i++) decide(4'($urandom_range(0, 15)), 0, 0, 0);
      decide(4'($urandom_range(0, 15)), 0, 1, 0);
      decide(4'($urandom_range(0, 15)), 0, 0, 0);

      // start and episode_end in the same IDLE cycle.
      do_reset();
      decide(4'h3, 1, 0, 0);
      check("same_cycle_epsilon", epsilon, 16'h00D8);
      check("same_cycle_pg_eps", pg_epsilon, 16'h00E0);

      // Epsilon decay sweep down to and holding at the floor.
      do_reset();
      for (int k = 1; k <= 27; k++) begin
         pulse_ee();
         check("eps_decay", epsilon, eps_model);
         if (k >= 23) check("eps_tail", epsilon, tail[k - 23]);
      end
      decide(4'h5, 0, 0, 0);

      // start held high for 10 cycles: two decisions, start in DONE ignored.
      do_reset();
      base = av_count;
      start = 1'b1;
      state_in = 4'h9;
      exp_q.push_back(pg_model(q_table[9], EPS_INIT));
      exp_q.push_back(pg_model(q_table[9], EPS_INIT));
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("burst_busy", busy, (k % 5) != 4);
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("burst_pulses", av_count - base, 2);
      check("burst_steps", step_count, 2);

      // Reset while in WAIT aborts the decision.
      start = 1'b1;
      state_in = 4'h7;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      base = av_count;
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_rd_en", qt_rd_en, 0);
      check("abort_av", action_valid, 0);
      check("abort_steps", step_count, 0);
      check("abort_epsilon", epsilon, EPS_INIT);
      check("abort_pg_q", pg_q_values, 0);
      @(negedge clk);
      rst = 1'b0;
      eps_model = EPS_INIT;
      step_model = 16'h0;
      repeat (6) @(negedge clk);
      check("abort_no_pulse", av_count - base, 0);
      check("abort_steps_after", step_count, 0);

      // Three decisions; episode_end coincident with the third action_valid.
      decide(4'h1, 0, 0, 0);
      decide(4'h2, 0, 0, 0);
      check("steps_before", step_count, 2);
      decide(4'h4, 0, 0, 1);
      check("steps_after", step_count, 0);

      repeat (2) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
